// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM state encoding,
// default operand width and the product-width helper.
package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int unsigned W_DEF = 16;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or after ptr,
// wrapping from NREQ-1 back to 0.
module mult_arbiter_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            any_req
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    win   = '0;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr + k never exceeds 2*NREQ-2, so one conditional subtract wraps it
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier between NREQ requesters with round-robin arbitration,
// sequences the ready/ack/Done_Flag handshake and aborts on a watchdog timeout.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic [NREQ-1:0]      req_gnt,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [prod_w(W)-1:0] rsp_product,
  output logic                 rsp_err,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  output logic                 mul_ready,
  output logic                 mul_ack,
  input  logic [prod_w(W)-1:0] producto,
  input  logic                 Done_Flag
);

  localparam int unsigned PW = prod_w(W);
  localparam int unsigned CW = $clog2(MAX_WAIT);

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, rr_nx;
  logic [IDW-1:0] cur_id, cur_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [W-1:0]   a_nx, b_nx;
  logic           ready_nx, ack_nx, rv_nx, rerr_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [IDW-1:0] rid_nx;
  logic [PW-1:0]  rp_nx;
  logic [IDW-1:0] win;
  logic           any_req;

  mult_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .win     (win),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_ready   <= 1'b0;
      mul_ack     <= 1'b0;
      req_gnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_nx;
      cur_id      <= cur_nx;
      cnt         <= cnt_nx;
      mul_a       <= a_nx;
      mul_b       <= b_nx;
      mul_ready   <= ready_nx;
      mul_ack     <= ack_nx;
      req_gnt     <= gnt_nx;
      rsp_valid   <= rv_nx;
      rsp_id      <= rid_nx;
      rsp_product <= rp_nx;
      rsp_err     <= rerr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    cur_nx   = cur_id;
    cnt_nx   = cnt;
    a_nx     = mul_a;
    b_nx     = mul_b;
    ready_nx = mul_ready;
    ack_nx   = 1'b0;
    gnt_nx   = '0;
    rv_nx    = 1'b0;
    rid_nx   = rsp_id;
    rp_nx    = rsp_product;
    rerr_nx  = rsp_err;

    unique case (state)
      ST_IDLE: begin
        // a stale Done_Flag must drain before anything is granted
        if (Done_Flag) begin
          state_nx = ST_RELEASE;
        end else if (any_req) begin
          a_nx     = req_a[win*W +: W];
          b_nx     = req_b[win*W +: W];
          gnt_nx   = NREQ'(1) << win;
          cur_nx   = win;
          rr_nx    = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          ready_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nx = cnt + 1'b1;
        if (Done_Flag) begin
          ready_nx = 1'b0;
          ack_nx   = 1'b1;
          rv_nx    = 1'b1;
          rid_nx   = cur_id;
          rp_nx    = producto;
          rerr_nx  = 1'b0;
          state_nx = ST_ACK;
        end else if (cnt == CW'(MAX_WAIT-1)) begin
          ready_nx = 1'b0;
          rv_nx    = 1'b1;
          rid_nx   = cur_id;
          rp_nx    = '0;
          rerr_nx  = 1'b1;
          state_nx = ST_ACK;
        end
      end
      ST_ACK: begin
        state_nx = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!Done_Flag) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
